buck_phase_scheduler: RTL and testbench

//  Sequencer for the two interleaved buck discharge channels. Owns the 4us period timers

---
 rtl/buck_sched_pkg.sv | 23 ++
 rtl/buck_phase_gate.sv | 87 ++++++++
 rtl/buck_phase_scheduler.sv | 159 +++++++++++++++
 tb/tb_buck_phase_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/buck_sched_pkg.sv
// buck_sched_pkg
//   Shared types and default timing constants for the buck phase scheduler.
//   - sched_state_e : run/stop sequencer states
//   - *_DEF         : default period, latch point, dead-time and related values
//   - TW            : width of timers and on-time values
package buck_sched_pkg;

    localparam int TW               = 16;
    localparam int PERIOD_DEF       = 400;
    localparam int PHASE_OFFSET_DEF = 200;
    localparam int LATCH_DEF        = 8;
    localparam int TON_MAX_DEF      = 200;
    localparam int DEAD_DEF         = 10;
    localparam int SS_STEP_DEF      = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STOP  = 2'd2,
        ST_FAULT = 2'd3
    } sched_state_e;

endpackage

// File: rtl/buck_phase_gate.sv
// buck_phase_gate
//   One buck channel: active flag, once-per-period on-time latch with clamp,
//   and registered hi/lo gate windows with dead-time.
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     timer             this channel's period timer (current value)
//     timer_nxt         value the timer takes on the next cycle
//     run, stop         sequencer is in RUN / STOP
//     kill              fault: clear active and gates on the next cycle
//     ton, limit        calculator on-time and current ceiling
//     active            channel is switching this period
//     gate_hi, gate_lo  high-side / low-side switch commands
module buck_phase_gate
    import buck_sched_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEF,
    parameter int LATCH  = LATCH_DEF,
    parameter int DEAD   = DEAD_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TW-1:0] timer,
    input  logic [TW-1:0] timer_nxt,
    input  logic          run,
    input  logic          stop,
    input  logic          kill,
    input  logic [TW-1:0] ton,
    input  logic [TW-1:0] limit,
    output logic          active,
    output logic          gate_hi,
    output logic          gate_lo
);

    // One extra bit so LATCH + ton + DEAD cannot wrap.
    typedef logic [TW:0] ext_t;

    logic          active_q, active_d;
    logic [TW-1:0] ton_lat_q, ton_lat_d;
    logic          gate_hi_q, gate_hi_d;
    logic          gate_lo_q, gate_lo_d;
    logic          wrap;
    ext_t          t_nxt, hi_end, lo_start;

    always_comb begin
        wrap      = (timer == TW'(PERIOD - 1));
        active_d  = active_q;
        ton_lat_d = ton_lat_q;

        // Channels only change activity at their own period boundary.
        if (wrap && run)
            active_d = 1'b1;
        else if (wrap && stop)
            active_d = 1'b0;
        if (kill)
            active_d = 1'b0;

        if (timer == TW'(LATCH))
            ton_lat_d = (ton > limit) ? limit : ton;

        // Gates are computed against next-cycle timer/latch/active so the
        // registered outputs line up with the timer value shown alongside.
        t_nxt     = ext_t'(timer_nxt);
        hi_end    = ext_t'(LATCH) + ext_t'(ton_lat_d);
        lo_start  = hi_end + ext_t'(DEAD);
        gate_hi_d = active_d && (t_nxt > ext_t'(LATCH)) && (t_nxt <= hi_end);
        gate_lo_d = active_d && (t_nxt > lo_start) && (t_nxt < ext_t'(PERIOD - DEAD));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            ton_lat_q <= '0;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
        end else begin
            active_q  <= active_d;
            ton_lat_q <= ton_lat_d;
            gate_hi_q <= gate_hi_d;
            gate_lo_q <= gate_lo_d;
        end
    end

    assign active  = active_q;
    assign gate_hi = gate_hi_q;
    assign gate_lo = gate_lo_q;

endmodule

// File: rtl/buck_phase_scheduler.sv
// buck_phase_scheduler
//   Sequencer for two interleaved buck channels: free-running phase-offset
//   period timers, run/stop/fault FSM, on-time ceiling, per-channel gating.
//   Optional feature macro: SOFT_START_EN (ramped on-time ceiling).
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     enable                run request (level; start needs a rising edge)
//     fault, fault_clr      fault level, single-cycle acknowledge
//     ton_0, ton_1          calculator on-times, cycles
//     timer_0, timer_1      channel period timers (timer_1 leads by PHASE_OFFSET)
//     gate_hi_0/1, gate_lo_0/1  switch commands
//     running               any channel active
//     fault_latched         sticky fault indication
module buck_phase_scheduler
    import buck_sched_pkg::*;
#(
`ifdef SOFT_START_EN
    parameter int SS_STEP      = SS_STEP_DEF,
`endif
    parameter int PERIOD       = PERIOD_DEF,
    parameter int PHASE_OFFSET = PHASE_OFFSET_DEF,
    parameter int LATCH        = LATCH_DEF,
    parameter int TON_MAX      = TON_MAX_DEF,
    parameter int DEAD         = DEAD_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          fault,
    input  logic          fault_clr,
    input  logic [TW-1:0] ton_0,
    input  logic [TW-1:0] ton_1,
    output logic [TW-1:0] timer_0,
    output logic [TW-1:0] timer_1,
    output logic          gate_hi_0,
    output logic          gate_hi_1,
    output logic          gate_lo_0,
    output logic          gate_lo_1,
    output logic          running,
    output logic          fault_latched
);

    sched_state_e  state_q, state_d;
    logic [TW-1:0] timer_0_q, timer_0_d;
    logic [TW-1:0] timer_1_q, timer_1_d;
    logic          enable_q;
    logic          fault_latched_q, fault_latched_d;
    logic          active_0, active_1;
    logic          rise, any_active, wrap_0;
    logic [TW-1:0] limit;

    always_comb begin
        wrap_0     = (timer_0_q == TW'(PERIOD - 1));
        timer_0_d  = wrap_0 ? '0 : timer_0_q + TW'(1);
        timer_1_d  = (timer_1_q == TW'(PERIOD - 1)) ? '0 : timer_1_q + TW'(1);
        rise       = enable && !enable_q;
        any_active = active_0 || active_1;

        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (rise) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = ST_STOP;
            ST_STOP: begin
                if (enable && any_active)
                    state_d = ST_RUN;
                else if (!any_active)
                    state_d = ST_IDLE;
            end
            ST_FAULT: if (fault_clr) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // Fault wins over everything, including a pending clear.
        if (fault)
            state_d = ST_FAULT;

        fault_latched_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            timer_0_q       <= '0;
            timer_1_q       <= TW'(PHASE_OFFSET);
            enable_q        <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_0_q       <= timer_0_d;
            timer_1_q       <= timer_1_d;
            enable_q        <= enable;
            fault_latched_q <= fault_latched_d;
        end
    end

`ifdef SOFT_START_EN
    // Ceiling restarts at one step on each fresh start and grows once per
    // channel-0 period; the period in which ch0 first goes active does not
    // count, so the first switching period uses exactly SS_STEP.
    typedef logic [TW:0] ext_t;
    logic [TW-1:0] limit_q, limit_d;
    ext_t          limit_sum;

    always_comb begin
        limit_sum = ext_t'(limit_q) + ext_t'(SS_STEP);
        limit_d   = limit_q;
        if (state_q == ST_IDLE && state_d == ST_RUN)
            limit_d = TW'(SS_STEP);
        else if (state_q == ST_RUN && wrap_0 && active_0)
            limit_d = (limit_sum >= ext_t'(TON_MAX)) ? TW'(TON_MAX) : limit_sum[TW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            limit_q <= TW'(SS_STEP);
        else
            limit_q <= limit_d;
    end

    assign limit = limit_q;
`else
    assign limit = TW'(TON_MAX);
`endif

    buck_phase_gate #(.PERIOD(PERIOD), .LATCH(LATCH), .DEAD(DEAD)) u_gate_0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .timer     (timer_0_q),
        .timer_nxt (timer_0_d),
        .run       (state_q == ST_RUN),
        .stop      (state_q == ST_STOP),
        .kill      (fault),
        .ton       (ton_0),
        .limit     (limit),
        .active    (active_0),
        .gate_hi   (gate_hi_0),
        .gate_lo   (gate_lo_0)
    );

    buck_phase_gate #(.PERIOD(PERIOD), .LATCH(LATCH), .DEAD(DEAD)) u_gate_1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .timer     (timer_1_q),
        .timer_nxt (timer_1_d),
        .run       (state_q == ST_RUN),
        .stop      (state_q == ST_STOP),
        .kill      (fault),
        .ton       (ton_1),
        .limit     (limit),
        .active    (active_1),
        .gate_hi   (gate_hi_1),
        .gate_lo   (gate_lo_1)
    );

    assign timer_0       = timer_0_q;
    assign timer_1       = timer_1_q;
    assign running       = active_0 || active_1;
    assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_buck_phase_scheduler.sv
module tb_buck_phase_scheduler;

    localparam int P  = 400;
    localparam int PH = 200;
    localparam int LT = 8;
    localparam int TM = 200;
    localparam int DT = 10;
    localparam int SS = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_STOP = 2, S_FAULT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0, fault = 1'b0, fault_clr = 1'b0;
    logic [15:0] ton_0 = 16'd0, ton_1 = 16'd0;
    logic [15:0] timer_0, timer_1;
    logic        gate_hi_0, gate_hi_1, gate_lo_0, gate_lo_1, running, fault_latched;

    buck_phase_scheduler dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fault(fault), .fault_clr(fault_clr),
        .ton_0(ton_0), .ton_1(ton_1), .timer_0(timer_0), .timer_1(timer_1),
        .gate_hi_0(gate_hi_0), .gate_hi_1(gate_hi_1), .gate_lo_0(gate_lo_0),
        .gate_lo_1(gate_lo_1), .running(running), .fault_latched(fault_latched)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time is counted in the model as cycles since reset; each channel's
    // position within its period follows from that. Gate levels are evaluated
    // directly from the window rules for the current timer value.
    int m_t0, m_st, m_lim;
    int m_lat [2];
    bit m_act [2];
    bit m_en_prev;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int tch(input int ch);
        return ch ? (m_t0 + PH) % P : m_t0;
    endfunction

    function automatic bit exp_hi(input int ch);
        int t = tch(ch);
        return m_act[ch] && t > LT && t <= LT + m_lat[ch];
    endfunction

    function automatic bit exp_lo(input int ch);
        int t = tch(ch);
        return m_act[ch] && t > LT + m_lat[ch] + DT && t < P - DT;
    endfunction

    task automatic model_reset();
        m_t0 = 0; m_st = S_IDLE; m_lim = TM; m_en_prev = 0;
`ifdef SOFT_START_EN
        m_lim = SS;
`endif
        for (int c = 0; c < 2; c++) begin m_act[c] = 0; m_lat[c] = 0; end
    endtask

    task automatic model_step();
        bit na [2];
        int nl [2];
        int nst, nlim, tn;
        bit any;
        for (int c = 0; c < 2; c++) begin
            int t = tch(c);
            tn = c ? int'(ton_1) : int'(ton_0);
            na[c] = m_act[c];
            if (t == P - 1 && m_st == S_RUN)  na[c] = 1;
            if (t == P - 1 && m_st == S_STOP) na[c] = 0;
            if (fault) na[c] = 0;
            nl[c] = (t == LT) ? imin(tn, m_lim) : m_lat[c];
        end
        any = m_act[0] || m_act[1];
        nst = m_st;
        if (m_st == S_IDLE && enable && !m_en_prev) nst = S_RUN;
        if (m_st == S_RUN && !enable) nst = S_RUN + 1;
        if (m_st == S_STOP) begin
            if (enable && any) nst = S_RUN;
            else if (!any)     nst = S_IDLE;
        end
        if (m_st == S_FAULT && fault_clr) nst = S_IDLE;
        if (fault) nst = S_FAULT;
        nlim = m_lim;
`ifdef SOFT_START_EN
        if (m_st == S_IDLE && nst == S_RUN) nlim = SS;
        else if (m_st == S_RUN && m_t0 == P - 1 && m_act[0]) nlim = imin(m_lim + SS, TM);
`endif
        m_t0 = (m_t0 + 1) % P;
        m_st = nst; m_lim = nlim; m_en_prev = enable;
        for (int c = 0; c < 2; c++) begin m_act[c] = na[c]; m_lat[c] = nl[c]; end
    endtask

    // Compare process: every cycle out of reset.
    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        if (rst_n) begin
            chk("m_timer_0", timer_0, m_t0);
            chk("m_timer_1", timer_1, (m_t0 + PH) % P);
            chk("m_hi_0", gate_hi_0, exp_hi(0));
            chk("m_lo_0", gate_lo_0, exp_lo(0));
            chk("m_hi_1", gate_hi_1, exp_hi(1));
            chk("m_lo_1", gate_lo_1, exp_lo(1));
            chk("m_running", running, m_act[0] || m_act[1]);
            chk("m_fault_latched", fault_latched, m_st == S_FAULT);
            chk("m_hi_lo_excl", gate_hi_0 & gate_lo_0 | gate_hi_1 & gate_lo_1, 0);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_ch(input int ch, input int v);
        int k = 0;
        int t;
        do begin
            @(negedge clk);
            k++;
            t = ch ? int'(timer_1) : int'(timer_0);
        end while (t != v && k < 2000);
        if (t != v) chk("wait_timer_bound", t, v);
    endtask

    task automatic measure(input int ch, output int hf, output int hl, output int hc,
                           output int lf, output int ll, output int lc);
        hf = -1; hl = -1; hc = 0; lf = -1; ll = -1; lc = 0;
        wait_ch(ch, 0);
        for (int i = 0; i < P; i++) begin
            int t = ch ? int'(timer_1) : int'(timer_0);
            if (ch ? gate_hi_1 : gate_hi_0) begin if (hc == 0) hf = t; hl = t; hc++; end
            if (ch ? gate_lo_1 : gate_lo_0) begin if (lc == 0) lf = t; ll = t; lc++; end
            @(negedge clk);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hf, hl, hc, lf, ll, lc, bad;
        bit ss;
        ss = 0;
`ifdef SOFT_START_EN
        ss = 1;
`endif
        // Reset
        #1 rst_n = 1'b0;
        #1;
        chk("rst_timer_0", timer_0, 0);
        chk("rst_timer_1", timer_1, 200);
        chk("rst_gates", {gate_hi_0, gate_lo_0, gate_hi_1, gate_lo_1}, 0);
        chk("rst_running", running, 0);
        chk("rst_fault_latched", fault_latched, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: basic run, ton 100/50
        @(negedge clk);
        ton_0 = 16'd100; ton_1 = 16'd50; enable = 1'b1;
        wait_ch(0, 1); wait_ch(0, 0);
        chk("t1_running", running, 1);
        if (!ss) begin
            measure(0, hf, hl, hc, lf, ll, lc);
            chk("t1_hi0_first", hf, 9);   chk("t1_hi0_last", hl, 108); chk("t1_hi0_cnt", hc, 100);
            chk("t1_lo0_first", lf, 119); chk("t1_lo0_last", ll, 389); chk("t1_lo0_cnt", lc, 271);
            measure(1, hf, hl, hc, lf, ll, lc);
            chk("t1_hi1_first", hf, 9);   chk("t1_hi1_last", hl, 58);
            chk("t1_lo1_first", lf, 69);  chk("t1_lo1_last", ll, 389);

            // 2: clamp and zero on-time
            ton_0 = 16'd350;
            measure(0, hf, hl, hc, lf, ll, lc);
            chk("t2_hi0_first", hf, 9);   chk("t2_hi0_last", hl, 208); chk("t2_hi0_cnt", hc, 200);
            chk("t2_lo0_first", lf, 219);
            ton_0 = 16'd0;
            measure(0, hf, hl, hc, lf, ll, lc);
            chk("t2_hi0_zero_cnt", hc, 0);
            chk("t2_lo0z_first", lf, 19); chk("t2_lo0z_last", ll, 389);
        end

        // 3: fault handling
        ton_0 = 16'd100;
        wait_ch(0, 50);
        chk("t3_hi0_before", gate_hi_0, ss ? 0 : 1);
        fault = 1'b1;
        @(negedge clk);
        fault = 1'b0;
        chk("t3_gates_off", {gate_hi_0, gate_lo_0, gate_hi_1, gate_lo_1}, 0);
        chk("t3_fault_latched", fault_latched, 1);
        chk("t3_running", running, 0);
        fault = 1'b1; fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0; fault = 1'b0;
        @(negedge clk);
        chk("t3_clr_ignored", fault_latched, 1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk("t3_cleared", fault_latched, 0);
        bad = 0;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if (gate_hi_0 | gate_lo_0 | gate_hi_1 | gate_lo_1 | running) bad++;
        end
        chk("t3_no_restart", bad, 0);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        wait_ch(0, 1); wait_ch(0, 0);
        chk("t3_restart_running", running, 1);

        // 4: orderly stop
        wait_ch(0, 50);
        enable = 1'b0;
        wait_ch(0, 100);
        chk("t4_hi0_finishing", gate_hi_0, ss ? 0 : 1);
        wait_ch(0, 150);
        chk("t4_lo1_finishing", gate_lo_1, 1);
        wait_ch(0, 230);
        chk("t4_hi1_stopped", gate_hi_1, 0);
        chk("t4_running_ch0", running, 1);
        wait_ch(0, 399);
        chk("t4_running_last", running, 1);
        wait_ch(0, 0);
        chk("t4_running_off", running, 0);
        repeat (3) @(negedge clk);
        chk("t4_idle_running", running, 0);

        // 5: async reset mid-run
        enable = 1'b1;
        wait_ch(0, 1); wait_ch(0, 0);
        wait_ch(0, 120);
        chk("t5_lo0_before", gate_lo_0, ss ? 0 : 1);
        rst_n = 1'b0;
        #1;
        chk("t5_gates", {gate_hi_0, gate_lo_0, gate_hi_1, gate_lo_1}, 0);
        chk("t5_running", running, 0);
        chk("t5_timer_0", timer_0, 0);
        chk("t5_timer_1", timer_1, 200);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_timer_0_run", timer_0, 1);
        chk("t5_timer_1_run", timer_1, 201);

        // 6: on-time ceiling over successive periods
        ton_0 = 16'd100;
        enable = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            measure(0, hf, hl, hc, lf, ll, lc);
            chk($sformatf("t6_width_p%0d", k), hc, ss ? imin(4 * k, 100) : 100);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
